// File: rtl/xbar_sched_pkg.sv
// Shared types, default parameters and the round-robin pick helper for xbar_sched.
package xbar_sched_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } sched_state_e;

  localparam int DEF_NUM_INPUT      = 4;
  localparam int DEF_NUM_OUTPUT     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 16;

  // Widest requester vector rr_pick can scan.
  localparam int RR_MAX_N   = 32;
  localparam int RR_IDX_W   = $clog2(RR_MAX_N);

  // First set bit of req at or after ptr, wrapping modulo n.
  function automatic int unsigned rr_pick(input logic [RR_MAX_N-1:0] req,
                                          input int unsigned         ptr,
                                          input int unsigned         n);
    int unsigned idx;
    logic        found;
    found   = 1'b0;
    rr_pick = 0;
    for (int unsigned k = 0; k < RR_MAX_N; k++) begin
      if (k < n && !found) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (req[idx[RR_IDX_W-1:0]]) begin
          found   = 1'b1;
          rr_pick = idx;
        end
      end
    end
  endfunction

endpackage

// File: rtl/xbar_sched_port.sv
// One output port of xbar_sched: IDLE/LOCKED FSM, round-robin pointer and owner.
// Stall-release counter present only when XBAR_SCHED_TIMEOUT_EN is defined.
module xbar_sched_port
  import xbar_sched_pkg::*;
#(
  parameter int NUM_INPUT      = DEF_NUM_INPUT,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int IW            = $clog2(NUM_INPUT)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_INPUT-1:0] cand,
  input  logic [NUM_INPUT-1:0] req_valid,
  input  logic [NUM_INPUT-1:0] req_last,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [IW-1:0]        sel,
  output logic [NUM_INPUT-1:0] grant_ready,
  output logic                 locked,
  output logic                 timeout
);

  if (NUM_INPUT < 2 || NUM_INPUT > RR_MAX_N || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("xbar_sched_port: illegal NUM_INPUT/TIMEOUT_CYCLES");
  end

  sched_state_e  state_q, state_d;
  logic [IW-1:0] owner_q, owner_d, ptr_q, ptr_d, owner_inc;
  logic          xfer, expire;

  assign owner_inc = (owner_q == IW'(NUM_INPUT - 1)) ? '0 : owner_q + IW'(1);
  assign xfer      = (state_q == LOCKED) && req_valid[owner_q] && out_ready;

`ifdef XBAR_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] stall_q;

  assign expire = (state_q == LOCKED) && (stall_q == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk_i) begin
    if (rst_i || state_q != LOCKED || xfer) stall_q <= '0;
    else if (!expire)                        stall_q <= stall_q + CW'(1);
  end
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  // Arbitration uses only request state, never out_ready.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (|cand) begin
          owner_d = IW'(rr_pick(RR_MAX_N'(cand), 32'(ptr_q), NUM_INPUT));
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (expire || (xfer && req_last[owner_q])) begin
          state_d = IDLE;
          ptr_d   = owner_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid   = 1'b0;
    grant_ready = '0;
    if (state_q == LOCKED) begin
      out_valid            = req_valid[owner_q];
      grant_ready[owner_q] = out_ready;
    end
  end

  // Select holds the last owner while idle so the crossbar mux never glitches.
  assign sel     = owner_q;
  assign locked  = (state_q == LOCKED);
  assign timeout = expire;

endmodule

// File: rtl/xbar_sched.sv
// Per-output packet scheduler steering handshakes and select_vector for xbar.
// Optional stall release per output enabled by defining XBAR_SCHED_TIMEOUT_EN.
module xbar_sched
  import xbar_sched_pkg::*;
#(
  parameter int NUM_INPUT      = DEF_NUM_INPUT,
  parameter int NUM_OUTPUT     = DEF_NUM_OUTPUT,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int IW            = $clog2(NUM_INPUT),
  localparam int DW            = $clog2(NUM_OUTPUT)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_INPUT-1:0]           req_valid_i,
  input  logic [NUM_INPUT-1:0][DW-1:0]   req_dest_i,
  input  logic [NUM_INPUT-1:0]           req_last_i,
  output logic [NUM_INPUT-1:0]           req_ready_o,
  input  logic [NUM_OUTPUT-1:0]          out_ready_i,
  output logic [NUM_OUTPUT-1:0]          out_valid_o,
  output logic [NUM_OUTPUT-1:0][IW-1:0]  select_vector_o,
  output logic [NUM_OUTPUT-1:0]          timeout_o
);

  logic [NUM_OUTPUT-1:0][NUM_INPUT-1:0] cand, grant_ready;
  logic [NUM_INPUT-1:0][NUM_OUTPUT-1:0] grant_ready_t;
  logic [NUM_OUTPUT-1:0]                locked;

  for (genvar o = 0; o < NUM_OUTPUT; o++) begin : g_port
    for (genvar i = 0; i < NUM_INPUT; i++) begin : g_cand
      assign cand[o][i]          = req_valid_i[i] && (req_dest_i[i] == DW'(o));
      assign grant_ready_t[i][o] = grant_ready[o][i];
    end

    xbar_sched_port #(
      .NUM_INPUT      (NUM_INPUT),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_port (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .cand        (cand[o]),
      .req_valid   (req_valid_i),
      .req_last    (req_last_i),
      .out_ready   (out_ready_i[o]),
      .out_valid   (out_valid_o[o]),
      .sel         (select_vector_o[o]),
      .grant_ready (grant_ready[o]),
      .locked      (locked[o]),
      .timeout     (timeout_o[o])
    );
  end

  // An input owns at most one output, so OR-ing the per-port readies is exact.
  for (genvar i = 0; i < NUM_INPUT; i++) begin : g_ready
    assign req_ready_o[i] = |grant_ready_t[i];
  end

`ifndef SYNTHESIS
  for (genvar o = 0; o < NUM_OUTPUT; o++) begin : g_dest_chk
    always_ff @(posedge clk_i) begin
      if (!rst_i && locked[o] && req_valid_i[select_vector_o[o]])
        assert (req_dest_i[select_vector_o[o]] == DW'(o))
          else $error("xbar_sched: input %0d changed destination mid-packet", select_vector_o[o]);
    end
  end
`endif

endmodule

// File: tb/tb_xbar_sched.sv
// Directed scoreboard bench for xbar_sched: per-input packet drivers, per-output expected queues.
module tb_xbar_sched;
  localparam int NI  = 4;
  localparam int NO  = 4;
  localparam int IW  = 2;
  localparam int DW  = 2;
  localparam int TMO = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NI-1:0]         req_valid, req_last, req_ready;
  logic [NI-1:0][DW-1:0] req_dest;
  logic [NO-1:0]         out_ready, out_valid, timeout;
  logic [NO-1:0][IW-1:0] sel;

  xbar_sched #(.NUM_INPUT(NI), .NUM_OUTPUT(NO), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_dest_i(req_dest),
    .req_last_i(req_last), .req_ready_o(req_ready), .out_ready_i(out_ready),
    .out_valid_o(out_valid), .select_vector_o(sel), .timeout_o(timeout));

  always #5 clk = ~clk;

  int            checks = 0, errors = 0, cycle = 0;
  int            exp_q[NO][$];
  int            pkt_dest[NI][$];
  int            pkt_len[NI][$];
  int            beats_left[NI];
  bit            active[NI];
  bit            hold[NI];
  logic [NI-1:0] acc, forbid_ready;
  bit            rst_prev = 1'b0;
  int            xfer_cyc[$];
  int            tmo_pulses[NO];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, want);
    end
  endtask

  // Queue a packet on input i and record the beats output d must deliver, in grant order.
  task automatic send(int i, int d, int len);
    pkt_dest[i].push_back(d);
    pkt_len[i].push_back(len);
    for (int b = 0; b < len; b++) exp_q[d].push_back(i * 2 + ((b == len - 1) ? 1 : 0));
  endtask

  task automatic drive();
    for (int i = 0; i < NI; i++) begin
      if (!active[i] && pkt_len[i].size() != 0) begin
        active[i]     = 1'b1;
        beats_left[i] = pkt_len[i].pop_front();
        req_dest[i]   = DW'(pkt_dest[i].pop_front());
      end
      req_valid[i] = active[i] && !hold[i];
      req_last[i]  = active[i] && (beats_left[i] == 1);
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int o = 0; o < NO; o++) n += exp_q[o].size();
    for (int i = 0; i < NI; i++) n += pkt_len[i].size() + (active[i] ? 1 : 0);
    return n;
  endfunction

  task automatic monitor();
    int want;
    acc = '0;
    if (rst) begin
      if (rst_prev) begin
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_select", 32'(sel), 0);
        check("rst_timeout", 32'(timeout), 0);
      end
      return;
    end
    if (forbid_ready != '0) check("waiting_input_ready", 32'(req_ready & forbid_ready), 0);
`ifndef XBAR_SCHED_TIMEOUT_EN
    check("timeout_disabled", 32'(timeout), 0);
`endif
    for (int o = 0; o < NO; o++) begin
      if (timeout[o]) tmo_pulses[o]++;
      if (out_valid[o] && out_ready[o]) begin
        checks++;
        assert (exp_q[o].size() != 0) else begin
          errors++;
          $error("FAIL xfer_unexpected_o%0d: observed input %0d, required no transfer", o, sel[o]);
        end
        if (exp_q[o].size() != 0) begin
          want = exp_q[o].pop_front();
          check($sformatf("xfer_o%0d_input_last", o), {29'b0, sel[o], req_last[sel[o]]}, want);
          check($sformatf("xfer_o%0d_req_ready", o), 32'(req_ready[sel[o]]), 1);
        end
        if (o == 2) xfer_cyc.push_back(cycle);
        acc[sel[o]] = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    rst_prev = rst;
    cycle++;
    #1;
    for (int i = 0; i < NI; i++) begin
      if (acc[i]) begin
        beats_left[i]--;
        if (beats_left[i] == 0) active[i] = 1'b0;
      end
    end
    drive();
  endtask

  task automatic drain(int budget, string tag);
    int n = 0;
    while (pending() != 0 && n < budget) begin
      step();
      n++;
    end
    checks++;
    assert (pending() == 0) else begin
      errors++;
      $error("FAIL %s_drain: observed %0d beats pending, required 0", tag, pending());
    end
  endtask

  task automatic abort_all();
    for (int i = 0; i < NI; i++) begin
      active[i] = 1'b0;
      hold[i]   = 1'b0;
      pkt_len[i].delete();
      pkt_dest[i].delete();
    end
    for (int o = 0; o < NO; o++) exp_q[o].delete();
    drive();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    out_ready    = '1;
    forbid_ready = '0;
    req_dest     = '0;
    for (int i = 0; i < NI; i++) begin active[i] = 1'b0; hold[i] = 1'b0; beats_left[i] = 0; end
    for (int o = 0; o < NO; o++) tmo_pulses[o] = 0;
    drive();
    @(posedge clk);
    #1;
    rst_prev = 1'b1;

    // Reset held while every input requests output 1
    for (int i = 0; i < NI; i++) send(i, 1, 1);
    drive();
    repeat (3) step();
    rst = 1'b0;
    #1;
    check("first_cycle_after_reset_idle", 32'(out_valid), 0);
    step();
    #1;
    check("first_grant_valid", 32'(out_valid), 32'h2);
    check("first_grant_select", 32'(sel[1]), 0);
    drain(40, "reset_grant");

    // Contention on output 2, two rounds of single-beat packets
    for (int r = 0; r < 2; r++) for (int i = 0; i < NI; i++) send(i, 2, 1);
    xfer_cyc.delete();
    drive();
    drain(60, "contention");
    check("contention_xfer_count", xfer_cyc.size(), 8);
    for (int k = 1; k < xfer_cyc.size(); k++)
      check($sformatf("contention_gap_%0d", k), xfer_cyc[k] - xfer_cyc[k-1], 2);

    // Packet lock: input 1 owns output 0 for 4 beats while input 3 waits
    send(1, 0, 4);
    send(3, 0, 2);
    forbid_ready = 4'b1000;
    drive();
    for (int n = 0; n < 40 && (active[1] || pkt_len[1].size() != 0); n++) begin
      step();
      out_ready[0] = ~out_ready[0];
    end
    forbid_ready = '0;
    out_ready    = '1;
    drain(40, "packet_lock");

    // Parallelism: crossed routing, all outputs lock together
    send(0, 3, 3);
    send(1, 2, 3);
    send(2, 1, 3);
    send(3, 0, 3);
    drive();
    step();
    #1;
    check("parallel_all_valid", 32'(out_valid), 32'hF);
    check("parallel_select", 32'(sel), {24'b0, 2'd0, 2'd1, 2'd2, 2'd3});
    drain(40, "parallel");

    // Reset during beat 2 of a 5-beat packet; output 1 pointer must restart at 0
    send(2, 1, 5);
    drive();
    for (int n = 0; n < 20 && exp_q[1].size() > 4; n++) step();
    check("midpkt_one_beat_done", exp_q[1].size(), 4);
    rst = 1'b1;
    abort_all();
    repeat (2) step();
    rst = 1'b0;
    #1;
    check("midpkt_post_reset_idle", 32'(out_valid), 0);
    send(0, 1, 1);
    send(3, 1, 1);
    drive();
    drain(40, "reset_midpkt");

`ifdef XBAR_SCHED_TIMEOUT_EN
    // Owner of output 3 stalls after one beat; lock must be force-released
    send(1, 3, 3);
    send(2, 3, 1);
    drive();
    for (int n = 0; n < 20 && exp_q[3].size() > 3; n++) step();
    hold[1] = 1'b1;
    drive();
    void'(exp_q[3].pop_front());
    void'(exp_q[3].pop_front());
    tmo_pulses[3] = 0;
    begin
      int n = 0;
      while (tmo_pulses[3] == 0 && n < 40) begin step(); n++; end
      check("timeout_stall_cycles", n, TMO + 1);
    end
    active[1] = 1'b0;
    hold[1]   = 1'b0;
    drive();
    drain(40, "timeout");
    check("timeout_pulse_count", tmo_pulses[3], 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
